lockin_result_emitter: RTL and testbench
========================================

Name: lockin_result_emitter

Overview:
Producer side of the result interface consumed by the control block. It sits between the lock-in accumulator datapath and control, and turns accumulator-done strobes into valid-qualified result streams:
- two 64-bit streams, written as up/down 32-bit halves to the processor FIFOs;
- two scaled, saturated 32-bit streams.
It applies decimation, counts emitted results against a processor-set target and raises calculo_finalizado when the run completes. It obeys control's enable and reset_from_control.

Parameters:
W_IN, 64, width of signed accumulator inputs and 64-bit outputs
W_CNT, 32, width of result/decimation counters
W_SH, 6, width of the scaling shift amount

Ports:
clk  in  1  system clock (clk_custom domain)
reset_n  in  1  asynchronous active-low reset
enable  in  1  run enable from control (already registered)
clear  in  1  synchronous clear, driven by reset_from_control
acc_in_0  in  W_IN  signed accumulator result, channel 0 (X)
acc_in_1  in  W_IN  signed accumulator result, channel 1 (Y)
acc_valid  in  1  one-cycle strobe, both acc_in_* valid
n_results  in  W_CNT  results to emit per run (parameter_out)
decimation  in  W_CNT  emit one of every N strobes; 0 is treated as 1
shift  in  W_SH  arithmetic right shift for 32-bit outputs
result_0_64_bit  out  W_IN  registered channel 0 result
result_1_64_bit  out  W_IN  registered channel 1 result
result_64_bit_valid  out  1  one-cycle strobe for both 64-bit results
result_0_32_bit  out  32  scaled, saturated channel 0
result_1_32_bit  out  32  scaled, saturated channel 1
result_32_bit_valid  out  1  one-cycle strobe for both 32-bit results
calculo_finalizado  out  1  level, run complete
results_emitted  out  W_CNT  emitted count (for parameter_in)

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - reset_n is asynchronous, active-low.
  - On reset: all outputs 0, state IDLE, decimation counter 0.
- States:
  - IDLE: go to RUN when enable=1 and n_results!=0. Entering RUN zeroes results_emitted and the decimation counter.
  - RUN: each acc_valid increments the decimation counter. When counter == max(decimation,1)-1:
    - counter returns to 0;
    - acc_in_* are captured into the 64-bit and 32-bit output registers;
    - both valid strobes go high for exactly one cycle, 1 cycle after acc_valid (latency 1);
    - results_emitted increments in the same cycle the valids assert.
  - RUN exits:
    - The emit that makes results_emitted == n_results moves the state to DONE. calculo_finalizado goes high the same cycle as that final valid.
    - enable=0 aborts to IDLE. calculo_finalizado stays 0 and results_emitted holds its value.
  - DONE: calculo_finalizado held at 1. Further acc_valid is ignored (no valids). enable=0 or clear returns to IDLE and drops calculo_finalizado.
- 32-bit path:
  - Compute acc >>> shift (arithmetic shift).
  - shift >= 63 yields 0 or -1 according to sign.
  - Saturate to [-2^31, 2^31-1].
  - Registered together with the 64-bit path; result_32_bit_valid is identical in timing to result_64_bit_valid.
- 64-bit path: unmodified two's-complement copy of acc_in_*.
- Output registers hold their last value between strobes. Valid strobes never assert for two consecutive cycles unless acc_valid does.
- Boundary conditions:
  - clear has top priority. It forces IDLE, zeroes counters, valids, calculo_finalizado and results_emitted, with effect the cycle after assertion. acc_valid coincident with clear produces no emit.
  - n_results changed mid-run: compared live. If the new value is <= results_emitted, the next emit moves to DONE.
  - decimation changed mid-run: the counter compares live against the new value. If counter >= new N-1, the next strobe emits and the counter resets.
  - results_emitted saturates at 2^W_CNT-1.
  - enable and acc_valid rising in the same cycle: that strobe is not counted; counting starts in RUN.

Decomposition:
- Package lockin_result_pkg: state enum (IDLE, RUN, DONE), W_IN/W_CNT/W_SH defaults, saturation limit constants SAT_MAX_32 and SAT_MIN_32.
- One sub-module, sat_shift_64to32: combinational arithmetic shift plus saturation, instantiated once per channel.

Test Plan:
- n_results=4, decimation=1, shift=0, 6 acc_valid strobes with acc_in_0=10..15 -> four valids carrying 10..13, each 1 cycle after its strobe; calculo_finalizado=1 with the 4th; results_emitted=4; strobes 5–6 ignored.
- decimation=3, n_results=2, 7 strobes -> emits on strobes 3 and 6 only; DONE after strobe 6; strobe 7 ignored.
- shift=4: acc_in_0=0x0000_0010_0000_0000 -> result_0_32_bit=0x7FFF_FFFF; acc_in_1=-0x100 -> result_1_32_bit=0xFFFF_FFF0. The 64-bit outputs are unchanged.
- Abort: enable dropped after 2 of 5 emits -> IDLE, calculo_finalizado=0, results_emitted=2. Re-enable -> count restarts at 0.
- clear asserted in the same cycle as a would-be emitting acc_valid -> no valid; all counters 0 the next cycle; calculo_finalizado=0.
- Async reset_n low mid-RUN between clock edges -> outputs 0 immediately; after release, IDLE with no spurious valid.

Source files
------------

// File: rtl/lockin_result_emitter_pkg.sv
// Shared types and constants for the lock-in result emitter: run-state encoding,
// default widths and the 32-bit saturation limits.
package lockin_result_pkg;

  localparam int DEF_W_IN  = 64;
  localparam int DEF_W_CNT = 32;
  localparam int DEF_W_SH  = 6;

  localparam logic signed [63:0] SAT_MAX_32 = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN_32 = -64'sh0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

endpackage

// File: rtl/lockin_result_emitter_if.sv
// Result/control bundle between the accumulator datapath, the emitter and control.
// master = emitter side, slave = the consumer/driver side.
interface lockin_result_emitter_if #(
  parameter int W_IN  = 64,
  parameter int W_CNT = 32,
  parameter int W_SH  = 6
);
  logic                    enable;
  logic                    clear;
  logic signed [W_IN-1:0]  acc_in_0;
  logic signed [W_IN-1:0]  acc_in_1;
  logic                    acc_valid;
  logic [W_CNT-1:0]        n_results;
  logic [W_CNT-1:0]        decimation;
  logic [W_SH-1:0]         shift;

  logic signed [W_IN-1:0]  result_0_64_bit;
  logic signed [W_IN-1:0]  result_1_64_bit;
  logic                    result_64_bit_valid;
  logic signed [31:0]      result_0_32_bit;
  logic signed [31:0]      result_1_32_bit;
  logic                    result_32_bit_valid;
  logic                    calculo_finalizado;
  logic [W_CNT-1:0]        results_emitted;

  modport master (
    input  enable, clear, acc_in_0, acc_in_1, acc_valid, n_results, decimation, shift,
    output result_0_64_bit, result_1_64_bit, result_64_bit_valid,
           result_0_32_bit, result_1_32_bit, result_32_bit_valid,
           calculo_finalizado, results_emitted
  );

  modport slave (
    output enable, clear, acc_in_0, acc_in_1, acc_valid, n_results, decimation, shift,
    input  result_0_64_bit, result_1_64_bit, result_64_bit_valid,
           result_0_32_bit, result_1_32_bit, result_32_bit_valid,
           calculo_finalizado, results_emitted
  );

endinterface

// File: rtl/lockin_result_emitter_sat_shift.sv
// Combinational arithmetic right shift of a wide signed accumulator followed by
// saturation to the signed 32-bit range.
module sat_shift_64to32
  import lockin_result_pkg::*;
#(
  parameter int W_IN = DEF_W_IN,
  parameter int W_SH = DEF_W_SH
) (
  input  logic signed [W_IN-1:0] acc,
  input  logic [W_SH-1:0]        shift,
  output logic signed [31:0]     result
);

  localparam logic signed [W_IN-1:0] MAX_W = W_IN'(SAT_MAX_32);
  localparam logic signed [W_IN-1:0] MIN_W = W_IN'(SAT_MIN_32);

  function automatic logic signed [31:0] sat_32(input logic signed [W_IN-1:0] v);
    if (v > MAX_W)      return 32'sh7FFF_FFFF;
    else if (v < MIN_W) return -32'sh8000_0000;
    else                return v[31:0];
  endfunction

  logic signed [W_IN-1:0] shifted;

  // Shifts at or beyond the sign bit collapse to pure sign extension.
  always_comb begin
    if (int'(shift) >= W_IN - 1) shifted = acc[W_IN-1] ? '1 : '0;
    else                         shifted = acc >>> shift;
  end

  assign result = sat_32(shifted);

endmodule

// File: rtl/lockin_result_emitter.sv
// Turns accumulator-done strobes into decimated, valid-qualified 64-bit and scaled
// 32-bit result streams, counting emits against a target and flagging run completion.
module lockin_result_emitter
  import lockin_result_pkg::*;
#(
  parameter int W_IN  = DEF_W_IN,
  parameter int W_CNT = DEF_W_CNT,
  parameter int W_SH  = DEF_W_SH
) (
  input logic                   clk,
  input logic                   reset_n,
  lockin_result_emitter_if.master bus
);

  run_state_e              state, state_nxt;
  logic [W_CNT-1:0]        dec_cnt, dec_cnt_nxt;
  logic [W_CNT-1:0]        emitted, emitted_nxt;
  logic                    fin, fin_nxt;
  logic                    emit;

  logic [W_CNT-1:0]        dec_thr;
  logic [W_CNT-1:0]        emitted_inc;

  logic signed [31:0]      sc_0, sc_1;

  logic signed [W_IN-1:0]  res64_0_p1, res64_1_p1;
  logic signed [31:0]      res32_0_p1, res32_1_p1;
  logic                    vld_p1;

  sat_shift_64to32 #(.W_IN(W_IN), .W_SH(W_SH)) u_sat_0 (
    .acc    (bus.acc_in_0),
    .shift  (bus.shift),
    .result (sc_0)
  );

  sat_shift_64to32 #(.W_IN(W_IN), .W_SH(W_SH)) u_sat_1 (
    .acc    (bus.acc_in_1),
    .shift  (bus.shift),
    .result (sc_1)
  );

  // Decimation of 0 behaves as 1, so the emit threshold is 0 in both cases.
  assign dec_thr     = (bus.decimation == '0) ? '0 : bus.decimation - 1'b1;
  assign emitted_inc = (emitted == '1) ? emitted : emitted + 1'b1;

  always_comb begin
    state_nxt   = state;
    dec_cnt_nxt = dec_cnt;
    emitted_nxt = emitted;
    fin_nxt     = fin;
    emit        = 1'b0;
    if (bus.clear) begin
      state_nxt   = IDLE;
      dec_cnt_nxt = '0;
      emitted_nxt = '0;
      fin_nxt     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          fin_nxt = 1'b0;
          if (bus.enable && (bus.n_results != '0)) begin
            state_nxt   = RUN;
            dec_cnt_nxt = '0;
            emitted_nxt = '0;
          end
        end
        RUN: begin
          if (!bus.enable) begin
            state_nxt = IDLE;
            fin_nxt   = 1'b0;
          end else if (bus.acc_valid) begin
            if (dec_cnt >= dec_thr) begin
              emit        = 1'b1;
              dec_cnt_nxt = '0;
              emitted_nxt = emitted_inc;
              if (emitted_inc >= bus.n_results) begin
                state_nxt = DONE;
                fin_nxt   = 1'b1;
              end
            end else begin
              dec_cnt_nxt = dec_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          fin_nxt = 1'b1;
          if (!bus.enable) begin
            state_nxt = IDLE;
            fin_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          fin_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dec_cnt <= '0;
      emitted <= '0;
      fin     <= 1'b0;
    end else begin
      state   <= state_nxt;
      dec_cnt <= dec_cnt_nxt;
      emitted <= emitted_nxt;
      fin     <= fin_nxt;
    end
  end

  // Stage p1: capture both paths together with their shared valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      res64_0_p1 <= '0;
      res64_1_p1 <= '0;
      res32_0_p1 <= '0;
      res32_1_p1 <= '0;
    end else begin
      vld_p1 <= emit;
      if (emit) begin
        res64_0_p1 <= bus.acc_in_0;
        res64_1_p1 <= bus.acc_in_1;
        res32_0_p1 <= sc_0;
        res32_1_p1 <= sc_1;
      end
    end
  end

  assign bus.result_0_64_bit     = res64_0_p1;
  assign bus.result_1_64_bit     = res64_1_p1;
  assign bus.result_64_bit_valid = vld_p1;
  assign bus.result_0_32_bit     = res32_0_p1;
  assign bus.result_1_32_bit     = res32_1_p1;
  assign bus.result_32_bit_valid = vld_p1;
  assign bus.calculo_finalizado  = fin;
  assign bus.results_emitted     = emitted;

endmodule

// File: tb/tb_lockin_result_emitter.sv
// Directed bench for lockin_result_emitter: run/decimation/scaling/abort/clear/reset.
module tb_lockin_result_emitter;

  logic clk = 1'b0;
  logic reset_n;
  int   errs = 0;
  int   checks = 0;

  lockin_result_emitter_if #(.W_IN(64), .W_CNT(32), .W_SH(6)) bus ();

  lockin_result_emitter #(.W_IN(64), .W_CNT(32), .W_SH(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic signed [63:0] a0, input logic signed [63:0] a1);
    bus.acc_in_0  = a0;
    bus.acc_in_1  = a1;
    bus.acc_valid = 1'b1;
    tick();
    bus.acc_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.enable = 1'b0; bus.clear = 1'b0; bus.acc_valid = 1'b0;
    bus.acc_in_0 = '0; bus.acc_in_1 = '0;
    bus.n_results = '0; bus.decimation = 32'd1; bus.shift = '0;
    #23;
    checks++;
    if (bus.result_64_bit_valid !== 1'b0 || bus.result_32_bit_valid !== 1'b0) begin
      errs++; $display("FAIL reset_valid: got %b/%b want 0/0", bus.result_64_bit_valid, bus.result_32_bit_valid);
    end
    checks++;
    if (bus.result_0_64_bit !== 64'd0 || bus.result_1_32_bit !== 32'd0 || bus.results_emitted !== 32'd0
        || bus.calculo_finalizado !== 1'b0) begin
      errs++; $display("FAIL reset_outputs: got r0=%0h r1_32=%0h emitted=%0d fin=%b want all 0",
                       bus.result_0_64_bit, bus.result_1_32_bit, bus.results_emitted, bus.calculo_finalizado);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_run();
    logic signed [63:0] e;
    bus.n_results = 32'd4; bus.decimation = 32'd1; bus.shift = '0;
    bus.enable = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      e = 64'(10 + i);
      strobe(e, -e);
      checks++;
      if (bus.result_64_bit_valid !== (i < 4) || bus.result_32_bit_valid !== (i < 4)) begin
        errs++; $display("FAIL basic_valid[%0d]: got %b/%b want %b", i,
                         bus.result_64_bit_valid, bus.result_32_bit_valid, (i < 4));
      end
      if (i < 4) begin
        checks++;
        if (bus.result_0_64_bit !== e || bus.result_1_64_bit !== -e || bus.result_0_32_bit !== 32'(e)) begin
          errs++; $display("FAIL basic_data[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                           bus.result_0_64_bit, bus.result_1_64_bit, bus.result_0_32_bit, e, -e, e);
        end
      end
      checks++;
      if (bus.results_emitted !== ((i < 4) ? 32'(i + 1) : 32'd4) || bus.calculo_finalizado !== (i >= 3)) begin
        errs++; $display("FAIL basic_count[%0d]: got emitted=%0d fin=%b want %0d/%b", i,
                         bus.results_emitted, bus.calculo_finalizado, (i < 4) ? i + 1 : 4, (i >= 3));
      end
      tick();
      checks++;
      if (bus.result_64_bit_valid !== 1'b0) begin
        errs++; $display("FAIL basic_valid_drop[%0d]: got %b want 0", i, bus.result_64_bit_valid);
      end
    end
    checks++;
    if (bus.result_0_64_bit !== 64'd13) begin
      errs++; $display("FAIL basic_hold: got %0d want 13", bus.result_0_64_bit);
    end
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.calculo_finalizado !== 1'b0) begin
      errs++; $display("FAIL basic_fin_drop: got %b want 0", bus.calculo_finalizado);
    end
  endtask

  task automatic test_decimation();
    bus.n_results = 32'd2; bus.decimation = 32'd3;
    bus.enable = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      strobe(64'(100 + i), 64'(200 + i));
      checks++;
      if (bus.result_64_bit_valid !== (i == 2 || i == 5)) begin
        errs++; $display("FAIL dec_valid[%0d]: got %b want %b", i, bus.result_64_bit_valid, (i == 2 || i == 5));
      end
      if (i == 2 || i == 5) begin
        checks++;
        if (bus.result_0_64_bit !== 64'(100 + i) || bus.result_1_64_bit !== 64'(200 + i)) begin
          errs++; $display("FAIL dec_data[%0d]: got %0d/%0d want %0d/%0d", i,
                           bus.result_0_64_bit, bus.result_1_64_bit, 100 + i, 200 + i);
        end
      end
    end
    checks++;
    if (bus.calculo_finalizado !== 1'b1 || bus.results_emitted !== 32'd2) begin
      errs++; $display("FAIL dec_done: got fin=%b emitted=%0d want 1/2", bus.calculo_finalizado, bus.results_emitted);
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic run_one(input logic [5:0] sh, input logic signed [63:0] a0, input logic signed [63:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1, input string nm);
    bus.n_results = 32'd1; bus.decimation = 32'd1; bus.shift = sh;
    bus.enable = 1'b1;
    tick();
    strobe(a0, a1);
    checks++;
    if (bus.result_32_bit_valid !== 1'b1 || bus.result_0_32_bit !== e0 || bus.result_1_32_bit !== e1) begin
      errs++; $display("FAIL %s_32: got v=%b %h/%h want 1 %h/%h", nm, bus.result_32_bit_valid,
                       bus.result_0_32_bit, bus.result_1_32_bit, e0, e1);
    end
    checks++;
    if (bus.result_0_64_bit !== a0 || bus.result_1_64_bit !== a1) begin
      errs++; $display("FAIL %s_64: got %h/%h want %h/%h", nm, bus.result_0_64_bit, bus.result_1_64_bit, a0, a1);
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_shift_saturate();
    run_one(6'd4, 64'h0000_0010_0000_0000, -64'sd256, 32'h7FFF_FFFF, 32'hFFFF_FFF0, "shift4");
    run_one(6'd63, 64'h7FFF_FFFF_FFFF_FFFF, -64'sd5, 32'h0000_0000, 32'hFFFF_FFFF, "shift63");
    run_one(6'd0, 64'sd123, -64'sh100_0000_0000, 32'd123, 32'h8000_0000, "satmin");
  endtask

  task automatic test_abort_restart();
    bus.n_results = 32'd5; bus.decimation = 32'd1; bus.shift = '0;
    bus.enable = 1'b1;
    tick();
    strobe(64'sd1, 64'sd2);
    strobe(64'sd3, 64'sd4);
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.calculo_finalizado !== 1'b0 || bus.results_emitted !== 32'd2) begin
      errs++; $display("FAIL abort_state: got fin=%b emitted=%0d want 0/2", bus.calculo_finalizado, bus.results_emitted);
    end
    strobe(64'sd9, 64'sd9);
    checks++;
    if (bus.result_64_bit_valid !== 1'b0) begin
      errs++; $display("FAIL abort_idle_strobe: got %b want 0", bus.result_64_bit_valid);
    end
    bus.enable = 1'b1;
    tick();
    checks++;
    if (bus.results_emitted !== 32'd0) begin
      errs++; $display("FAIL restart_count: got %0d want 0", bus.results_emitted);
    end
    strobe(64'sd5, 64'sd6);
    strobe(64'sd7, 64'sd8);
    bus.n_results = 32'd1;
    strobe(64'sd11, 64'sd12);
    checks++;
    if (bus.result_64_bit_valid !== 1'b1 || bus.calculo_finalizado !== 1'b1 || bus.results_emitted !== 32'd3) begin
      errs++; $display("FAIL live_n_results: got v=%b fin=%b emitted=%0d want 1/1/3",
                       bus.result_64_bit_valid, bus.calculo_finalizado, bus.results_emitted);
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    bus.n_results = 32'd5; bus.decimation = 32'd1;
    bus.enable = 1'b1;
    tick();
    strobe(64'sd21, 64'sd22);
    bus.clear = 1'b1;
    strobe(64'sd31, 64'sd32);
    bus.clear = 1'b0;
    checks++;
    if (bus.result_64_bit_valid !== 1'b0 || bus.results_emitted !== 32'd0 || bus.calculo_finalizado !== 1'b0) begin
      errs++; $display("FAIL clear: got v=%b emitted=%0d fin=%b want 0/0/0",
                       bus.result_64_bit_valid, bus.results_emitted, bus.calculo_finalizado);
    end
    checks++;
    if (bus.result_0_64_bit !== 64'sd21) begin
      errs++; $display("FAIL clear_hold: got %0d want 21", bus.result_0_64_bit);
    end
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.n_results = 32'd5; bus.decimation = 32'd1;
    bus.enable = 1'b1;
    tick();
    strobe(64'sd77, 64'sd78);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.result_0_64_bit !== 64'd0 || bus.result_64_bit_valid !== 1'b0 || bus.results_emitted !== 32'd0
        || bus.result_0_32_bit !== 32'd0) begin
      errs++; $display("FAIL async_reset: got r0=%0d v=%b emitted=%0d r0_32=%0d want 0",
                       bus.result_0_64_bit, bus.result_64_bit_valid, bus.results_emitted, bus.result_0_32_bit);
    end
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.result_64_bit_valid !== 1'b0 || bus.results_emitted !== 32'd0 || bus.calculo_finalizado !== 1'b0) begin
      errs++; $display("FAIL post_reset: got v=%b emitted=%0d fin=%b want 0/0/0",
                       bus.result_64_bit_valid, bus.results_emitted, bus.calculo_finalizado);
    end
    bus.enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_decimation();
    test_shift_saturate();
    test_abort_restart();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
